uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have the parameter PRESCALE, default 8, giving CLK cycles per bit; legal values are even and 4..32.
REQ-003 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port RST, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have the port RX_IN, input, 1 bit: the serial line, idle high, asynchronous to CLK.
REQ-006 The block SHALL have the port PAR_EN, input, 1 bit: 1 means a parity bit follows the data bits.
REQ-007 The block SHALL have the port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 The block SHALL have the port P_DATA, output, DATA_WIDTH bits: the received data word.
REQ-009 The block SHALL have the port DATA_VALID, output, 1 bit: a one-cycle pulse marking a frame with no errors.
REQ-010 The block SHALL have the port PAR_ERR, output, 1 bit: parity mismatch in the last frame.
REQ-011 The block SHALL have the port STP_ERR, output, 1 bit: stop bit sampled low in the last frame.

Function
REQ-012 Frame format SHALL be: start (0), then DATA_WIDTH data bits LSB first, then an optional parity bit, then one stop bit (1).
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 IDLE SHALL go to START when rx_s=0, clearing edge_cnt=0, bit_cnt=0, PAR_ERR and STP_ERR.
REQ-016 edge_cnt SHALL count 0..PRESCALE-1 per bit and wrap to 0; a bit ends on the cycle where edge_cnt=PRESCALE-1.
REQ-017 Each bit value SHALL be the majority of rx_s sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, and is final at edge_cnt=PRESCALE/2+2.
REQ-018 START SHALL return to IDLE at the end of the bit if the sampled start bit is 1 (glitch rejection); otherwise it goes to DATA.
REQ-019 DATA SHALL shift the sampled bit into P_DATA at bit position bit_cnt, and go to PARITY (PAR_EN=1) or STOP (PAR_EN=0) when bit_cnt reaches DATA_WIDTH-1.
REQ-020 PARITY SHALL set PAR_ERR=1 at the end of the bit if the sampled bit differs from (XOR of P_DATA) XOR PAR_TYP.
REQ-021 STOP SHALL set STP_ERR=1 if the sampled stop bit is 0.
REQ-022 At the end of STOP, DATA_VALID SHALL pulse high for exactly one cycle if PAR_ERR=0 and STP_ERR=0 (including the error just detected), and the FSM returns to IDLE.
REQ-023 P_DATA SHALL hold its value from the end of STOP until the next START.
REQ-024 PAR_ERR and STP_ERR SHALL hold until the next start detection or reset.
REQ-025 Back-to-back frames: if rx_s=0 in the first IDLE cycle after STOP, reception SHALL start with no lost cycles.
REQ-026 PAR_EN and PAR_TYP SHALL be sampled only at start detection; changes mid-frame have no effect on the frame in progress.

Reset
REQ-027 RST low SHALL asynchronously force: FSM=IDLE, counters=0, synchronizer flops=1, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no DATA_VALID; after release, the block waits for a fresh falling edge.

Structure
REQ-029 The FSM state encodings and the edge-sample offsets SHALL reside in shared package uart_pkg, which is also used by the transmitter.
REQ-030 Majority-vote sampling SHALL be a sub-module named data_sampling (inputs rx_s and edge_cnt; output sampled_bit); the FSM, counters and deserializer stay in uart_rx.

Verification (DATA_WIDTH=8, PRESCALE=8)
REQ-031 Frame 0xA5 with PAR_EN=1 and PAR_TYP=0 (parity bit 0) -> P_DATA=0xA5, one DATA_VALID pulse, PAR_ERR=0, STP_ERR=0.
REQ-032 The same frame with parity bit 1 -> PAR_ERR=1, no DATA_VALID.
REQ-033 Frame 0x3C with PAR_EN=0 and stop bit 0 -> STP_ERR=1, no DATA_VALID, FSM in IDLE afterwards.
REQ-034 RX_IN low for 2 cycles and then high -> FSM returns to IDLE, with no flags and no DATA_VALID.
REQ-035 Frames 0x3C and 0xC3 sent back-to-back with PAR_EN=1 and PAR_TYP=1 -> two DATA_VALID pulses 11*8 cycles apart, with P_DATA 0x3C then 0xC3.
REQ-036 RST pulsed during data bit 4, then frame 0x5A -> no pulse for the aborted frame, then P_DATA=0x5A with DATA_VALID.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver/transmitter FSM states
// and mid-bit sample offsets used by the majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Sample points relative to the middle of a bit (PRESCALE/2)
    localparam int SMP_EARLY = -1;
    localparam int SMP_MID   = 0;
    localparam int SMP_LATE  = 1;

    function automatic int smp_pos(input int prescale, input int ofs);
        return prescale / 2 + ofs;
    endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Majority vote of three samples taken around the bit centre.
// The late sample is bypassed live so the vote is ready at bit end.
module data_sampling
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int EW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_s,
    input  logic [EW-1:0] edge_cnt,
    output logic          sampled_bit
);

    localparam logic [EW-1:0] P_EARLY = EW'(smp_pos(PRESCALE, SMP_EARLY));
    localparam logic [EW-1:0] P_MID   = EW'(smp_pos(PRESCALE, SMP_MID));
    localparam logic [EW-1:0] P_LATE  = EW'(smp_pos(PRESCALE, SMP_LATE));

    logic s0_q, s1_q, s2_q;
    logic s2;

    // Capture the line at each of the three sample points
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            if (edge_cnt == P_EARLY) s0_q <= rx_s;
            if (edge_cnt == P_MID)   s1_q <= rx_s;
            if (edge_cnt == P_LATE)  s2_q <= rx_s;
        end
    end

    assign s2          = (edge_cnt == P_LATE) ? rx_s : s2_q;
    assign sampled_bit = (s0_q & s1_q) | (s0_q & s2) | (s1_q & s2);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, oversampling bit timer,
// frame FSM with optional parity and stop-bit checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  sampled_bit;
    logic                  bit_end;

    data_sampling #(
        .PRESCALE (PRESCALE),
        .EW       (EW)
    ) u_sample (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_s        (rx_s_q),
        .edge_cnt    (edge_q),
        .sampled_bit (sampled_bit)
    );

    assign bit_end = (edge_q == EDGE_LAST);

    // State, counters, deserialiser and flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    // Next-state logic; the detect cycle counts as edge 0 of the start bit
    always_comb begin
        state_d   = state_q;
        edge_d    = bit_end ? '0 : edge_q + 1'b1;
        bit_d     = bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        unique case (state_q)
            IDLE: begin
                edge_d = '0;
                if (!rx_s_q) begin
                    state_d   = START;
                    edge_d    = EW'(1);
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START: begin
                if (bit_end) state_d = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    data_d[bit_q] = sampled_bit;
                    if (bit_q == BIT_LAST)
                        state_d = par_en_q ? PARITY : STOP;
                    else
                        bit_d = bit_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != ((^data_q) ^ par_typ_q))
                        par_err_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!sampled_bit) stp_err_d = 1'b1;
                    valid_d = sampled_bit & ~par_err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign P_DATA     = data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DATA_WIDTH=8, PRESCALE=8.
module tb_uart_rx;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] vdata[$];
    int         vcyc[$];
    int         n0;

    uart_rx #(
        .DATA_WIDTH (8),
        .PRESCALE   (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            vdata.push_back(P_DATA);
            vcyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (8) @(negedge CLK);
    endtask

    // Parity controls flip after the start bit: only the latched values count
    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pbit,
                              input logic sbit);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        drive_bit(1'b0);
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
        RX_IN = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_eq("rst_pdata", 32'(P_DATA), 32'h0);
        check_eq("rst_valid", 32'(DATA_VALID), 32'h0);
        check_eq("rst_parerr", 32'(PAR_ERR), 32'h0);
        check_eq("rst_stperr", 32'(STP_ERR), 32'h0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // 0xA5, even parity, correct parity bit 0
        n0 = vdata.size();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (12) @(negedge CLK);
        check_eq("t1_npulse", 32'(vdata.size() - n0), 32'd1);
        if (vdata.size() > n0)
            check_eq("t1_pdata", 32'(vdata[n0]), 32'hA5);
        check_eq("t1_parerr", 32'(PAR_ERR), 32'h0);
        check_eq("t1_stperr", 32'(STP_ERR), 32'h0);

        // Same frame, wrong parity bit
        n0 = vdata.size();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (12) @(negedge CLK);
        check_eq("t2_npulse", 32'(vdata.size() - n0), 32'd0);
        check_eq("t2_parerr", 32'(PAR_ERR), 32'h1);
        check_eq("t2_stperr", 32'(STP_ERR), 32'h0);

        // 0x3C, no parity, stop bit low
        n0 = vdata.size();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge CLK);
        check_eq("t3_npulse", 32'(vdata.size() - n0), 32'd0);
        check_eq("t3_stperr", 32'(STP_ERR), 32'h1);
        check_eq("t3_parerr", 32'(PAR_ERR), 32'h0);
        check_eq("t3_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("t3_pdata", 32'(P_DATA), 32'h3C);

        // Two-cycle glitch on the line
        n0 = vdata.size();
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        check_eq("t4_npulse", 32'(vdata.size() - n0), 32'd0);
        check_eq("t4_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("t4_parerr", 32'(PAR_ERR), 32'h0);
        check_eq("t4_stperr", 32'(STP_ERR), 32'h0);

        // Back-to-back, odd parity: both bytes have four ones -> bit 1
        n0 = vdata.size();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (12) @(negedge CLK);
        check_eq("t5_npulse", 32'(vdata.size() - n0), 32'd2);
        if (vdata.size() >= n0 + 2) begin
            check_eq("t5_data0", 32'(vdata[n0]), 32'h3C);
            check_eq("t5_data1", 32'(vdata[n0+1]), 32'hC3);
            check_eq("t5_gap", 32'(vcyc[n0+1] - vcyc[n0]), 32'd88);
        end
        check_eq("t5_parerr", 32'(PAR_ERR), 32'h0);

        // Reset in the middle of data bit 4, then a clean 0x5A
        n0 = vdata.size();
        PAR_EN = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("t6_rst_pdata", 32'(P_DATA), 32'h0);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        check_eq("t6_abort_np", 32'(vdata.size() - n0), 32'd0);
        check_eq("t6_state", 32'(dut.state_q), 32'(IDLE));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) @(negedge CLK);
        check_eq("t6_npulse", 32'(vdata.size() - n0), 32'd1);
        if (vdata.size() > n0)
            check_eq("t6_pdata", 32'(vdata[n0]), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
